// File: rtl/decode_stage_rf.sv
// rtl/decode_stage_rf.sv - decode stage: field decode, bypassed register bank, ID/EX register, load-use detect
module decode_stage_rf #(
  parameter int         XLEN     = 32,
  parameter int         NREG     = 32,
  parameter bit         ZERO_REG = 1'b1,
  parameter logic [5:0] LOAD_OP  = 6'b100011,
  parameter logic [5:0] STORE_OP = 6'b101011,
  localparam int        RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     npc_if,
  input  logic [31:0]     ir_if,
  output logic            id_ready,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_valid,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] d,
  output logic [XLEN-1:0] imm,
  output logic [31:0]     npc_id,
  output logic [31:0]     ir_id,
  output logic [RW-1:0]   rd_id,
  output logic            hazard
);

  // Register 0 is hardwired to zero when ZERO_REG is set.
  function automatic logic is_zero(input logic [RW-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  // Index equality that never matches on a hardwired-zero register.
  function automatic logic idx_match(input logic [RW-1:0] x, input logic [RW-1:0] y);
    return (x == y) && !is_zero(x);
  endfunction

  logic [XLEN-1:0] regs_q [NREG];

  logic [5:0]      op_f;
  logic [RW-1:0]   rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] a_d, b_d, d_d, imm_d;
  logic            load_in_ex;

  logic            id_valid_q;
  logic [XLEN-1:0] a_q, b_q, d_q, imm_q;
  logic [31:0]     npc_id_q, ir_id_q;
  logic [RW-1:0]   rd_id_q;

  assign op_f  = ir_if[31:26];
  assign rd_f  = ir_if[21 +: RW];
  assign rs1_f = ir_if[16 +: RW];
  assign rs2_f = ir_if[11 +: RW];
  assign imm_d = {{(XLEN-16){ir_if[15]}}, ir_if[15:0]};

  // Read ports: zero register first, then same-cycle write-back bypass, then the bank.
  assign a_d = is_zero(rs1_f) ? '0 : (wb_en && wb_rd == rs1_f) ? wb_data : regs_q[rs1_f];
  assign b_d = is_zero(rs2_f) ? '0 : (wb_en && wb_rd == rs2_f) ? wb_data : regs_q[rs2_f];
  assign d_d = is_zero(rd_f)  ? '0 : (wb_en && wb_rd == rd_f)  ? wb_data : regs_q[rd_f];

  // A load sitting in ID/EX whose destination feeds the incoming instruction forces one bubble.
  assign load_in_ex = id_valid_q && (ir_id_q[31:26] == LOAD_OP);
  assign hazard     = load_in_ex && if_valid &&
                      (idx_match(rd_id_q, rs1_f) || idx_match(rd_id_q, rs2_f) ||
                       ((op_f == STORE_OP) && idx_match(rd_id_q, rd_f)));

  assign id_ready = flush | (~ex_stall & ~hazard);

  // Register bank write port; index 0 ignores writes when hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && !is_zero(wb_rd)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // ID/EX boundary: flush beats stall, stall holds everything, hazard inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      imm_q      <= '0;
      npc_id_q   <= '0;
      ir_id_q    <= '0;
      rd_id_q    <= '0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (ex_stall) begin
      id_valid_q <= id_valid_q;
    end else if (hazard) begin
      id_valid_q <= 1'b0;
    end else begin
      id_valid_q <= if_valid;
      a_q        <= a_d;
      b_q        <= b_d;
      d_q        <= d_d;
      imm_q      <= imm_d;
      npc_id_q   <= npc_if;
      ir_id_q    <= ir_if;
      rd_id_q    <= rd_f;
    end
  end

  assign id_valid = id_valid_q;
  assign a        = a_q;
  assign b        = b_q;
  assign d        = d_q;
  assign imm      = imm_q;
  assign npc_id   = npc_id_q;
  assign ir_id    = ir_id_q;
  assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_decode_stage_rf.sv
// tb/tb_decode_stage_rf.sv - scoreboard bench for decode_stage_rf
module tb_decode_stage_rf;

  localparam logic [5:0] LD = 6'b100011;
  localparam logic [5:0] ST = 6'b101011;
  localparam logic [5:0] AL = 6'b001000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] npc_if, ir_if;
  logic        id_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        id_valid;
  logic [31:0] a, b, d, imm, npc_id, ir_id;
  logic [4:0]  rd_id;
  logic        hazard;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_rf [32];
  logic [31:0] npc_ctr = 32'h0000_1000;

  typedef struct {
    logic        v;
    logic [31:0] a, b, d, imm, npc, ir;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  exp_t last;

  decode_stage_rf dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .npc_if(npc_if), .ir_if(ir_if),
    .id_ready(id_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .id_valid(id_valid), .a(a), .b(b), .d(d),
    .imm(imm), .npc_id(npc_id), .ir_id(ir_id), .rd_id(rd_id), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm16);
    return {op, rd, rs1, imm16};
  endfunction

  function automatic logic [31:0] rd_exp(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_rd == idx) return wb_data;
    return ref_rf[idx];
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd,
                       input logic st, input logic fl);
    if_valid = v;
    ir_if    = ir;
    npc_if   = npc_ctr;
    npc_ctr  = npc_ctr + 32'd4;
    wb_en    = we;
    wb_rd    = wrd;
    wb_data  = wd;
    ex_stall = st;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    we = wb_en; wr = wb_rd; wd = wb_data;
    @(posedge clk);
    if (we && wr != 5'd0) ref_rf[wr] = wd;
    #1;
  endtask

  task automatic cyc_normal(input string tag);
    exp_t e;
    e.v   = if_valid;
    e.a   = rd_exp(ir_if[20:16]);
    e.b   = rd_exp(ir_if[15:11]);
    e.d   = rd_exp(ir_if[25:21]);
    e.imm = {{16{ir_if[15]}}, ir_if[15:0]};
    e.npc = npc_if;
    e.ir  = ir_if;
    e.rd  = ir_if[25:21];
    check({tag, ".ready"}, {31'b0, id_ready}, 32'd1);
    check({tag, ".hazard"}, {31'b0, hazard}, 32'd0);
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    last = e;
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, e.v});
    check({tag, ".a"}, a, e.a);
    check({tag, ".b"}, b, e.b);
    check({tag, ".d"}, d, e.d);
    check({tag, ".imm"}, imm, e.imm);
    check({tag, ".npc"}, npc_id, e.npc);
    check({tag, ".ir"}, ir_id, e.ir);
    check({tag, ".rd"}, {27'b0, rd_id}, {27'b0, e.rd});
  endtask

  task automatic check_hold(input string tag);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, last.v});
    check({tag, ".a"}, a, last.a);
    check({tag, ".b"}, b, last.b);
    check({tag, ".d"}, d, last.d);
    check({tag, ".ir"}, ir_id, last.ir);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".valid"}, {31'b0, id_valid}, 32'd0);
    check({tag, ".a"}, a, 32'd0);
    check({tag, ".b"}, b, 32'd0);
    check({tag, ".d"}, d, 32'd0);
    check({tag, ".imm"}, imm, 32'd0);
    check({tag, ".npc"}, npc_id, 32'd0);
    check({tag, ".ir"}, ir_id, 32'd0);
    check({tag, ".rd"}, {27'b0, rd_id}, 32'd0);
    check({tag, ".ready"}, {31'b0, id_ready}, 32'd1);
    check({tag, ".hazard"}, {31'b0, hazard}, 32'd0);
  endtask

  task automatic load_use(input string tag, input logic [31:0] dep_ir, input logic expect_hz);
    drive(1'b1, mk(LD, 5'd7, 5'd3, 16'h0010), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal({tag, ".ld"});
    drive(1'b1, dep_ir, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    if (expect_hz) begin
      check({tag, ".hz"}, {31'b0, hazard}, 32'd1);
      check({tag, ".hz_ready"}, {31'b0, id_ready}, 32'd0);
      tick();
      check({tag, ".bubble"}, {31'b0, id_valid}, 32'd0);
      drive(1'b1, dep_ir, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end
    cyc_normal({tag, ".dep"});
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; npc_if = '0; ir_if = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    ex_stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_zero_outputs("reset");

    drive(1'b1, mk(AL, 5'd1, 5'd5, 16'h2800), 1'b1, 5'd5, 32'h1111_1111, 1'b0, 1'b0);
    cyc_normal("pre");

    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    #1 check_zero_outputs("async_rst");
    #1 rst = 1'b0;
    tick();
    drive(1'b1, mk(AL, 5'd5, 5'd5, 16'h2800), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("r5_after_rst");
    check("r5_after_rst.const", a, 32'h0);

    drive(1'b1, mk(AL, 5'd1, 5'd5, 16'h0000), 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc_normal("bypass");
    check("bypass.const", a, 32'hDEAD_BEEF);
    drive(1'b1, mk(AL, 5'd1, 5'd5, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("r5_read");
    check("r5_read.const", a, 32'hDEAD_BEEF);

    drive(1'b1, mk(AL, 5'd0, 5'd0, 16'h0000), 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
    cyc_normal("zero_byp");
    drive(1'b1, mk(AL, 5'd0, 5'd0, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("zero_rd");
    check("zero_rd.const", a | b | d, 32'h0);

    drive(1'b0, 32'h0, 1'b1, 5'd7, 32'h7777_7777, 1'b0, 1'b0); cyc_normal("wr7");
    drive(1'b0, 32'h0, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 1'b0); cyc_normal("wr3");
    drive(1'b0, 32'h0, 1'b1, 5'd9, 32'h9999_9999, 1'b0, 1'b0); cyc_normal("wr9");
    drive(1'b0, 32'h0, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b0); cyc_normal("wr2");

    load_use("lu_rs2", mk(AL, 5'd2, 5'd9, {5'd7, 11'h000}), 1'b1);
    load_use("lu_rs1", mk(AL, 5'd2, 5'd7, {5'd9, 11'h000}), 1'b1);
    load_use("lu_st",  mk(ST, 5'd7, 5'd9, {5'd2, 11'h004}), 1'b1);
    load_use("lu_none", mk(AL, 5'd7, 5'd9, {5'd2, 11'h000}), 1'b0);

    drive(1'b1, mk(LD, 5'd0, 5'd3, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("ld_r0");
    drive(1'b1, mk(AL, 5'd1, 5'd0, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("ld_r0.dep");

    drive(1'b1, mk(AL, 5'd9, 5'd3, {5'd7, 11'h011}), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("stall_src");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(AL, 5'd4, 5'd3, {5'd2, 11'h000}), 1'b1, 5'd3, 32'hAAAA_0000 + k, 1'b1, 1'b0);
      check($sformatf("stall%0d.ready", k), {31'b0, id_ready}, 32'd0);
      tick();
      check_hold($sformatf("stall%0d", k));
    end
    drive(1'b1, mk(AL, 5'd4, 5'd3, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check("flush.ready", {31'b0, id_ready}, 32'd1);
    tick();
    check("flush.valid", {31'b0, id_valid}, 32'd0);
    drive(1'b1, mk(AL, 5'd9, 5'd3, {5'd7, 11'h011}), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("post_stall");
    check("post_stall.const", a, 32'hAAAA_0002);

    drive(1'b1, mk(AL, 5'd1, 5'd2, 16'h8000), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("imm_neg");
    check("imm_neg.const", imm, 32'hFFFF_8000);
    drive(1'b1, mk(AL, 5'd1, 5'd2, 16'h7FFF), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    cyc_normal("imm_pos");
    check("imm_pos.const", imm, 32'h0000_7FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
